sqrt_bus_master: RTL and testbench
==================================

Name: sqrt_bus_master

Overview:
- Bus initiator that drives the sqrt peripheral's memory-mapped slave port (cs/rd/wr/addr/data). It is the requesting end of the protocol the peripheral responds to.
- On a host request it runs a fixed transaction sequence:
  - write the operand;
  - write the init command;
  - poll the done register;
  - read the result;
  - return the result on a valid/ready response port.
- Sits between a host/control FSM and one sqrt peripheral instance.

Parameters:
- ADDR_A, 5'h04, operand register address
- ADDR_INIT, 5'h0C, init/start register address
- ADDR_DONE, 5'h10, done status register address (bit 0 = done)
- ADDR_RES, 5'h14, result register address
- POLL_GAP, 4, idle cycles before each done poll (legal 1..15)
- TIMEOUT, 255, maximum number of done polls before abort (used only with the optional feature)

Ports:
- clk in 1: system clock, all logic on rising edge
- reset in 1: asynchronous, active-low; all state cleared while low
- req_valid in 1: host request strobe
- req_ready out 1: high only in IDLE
- req_operand in 16: radicand
- rsp_valid out 1: result available
- rsp_ready in 1: host accepts result
- rsp_data out 32: result word read from ADDR_RES
- rsp_err out 1: abort flag; qualified by rsp_valid
- busy out 1: high in every state except IDLE
- cs out 1: peripheral chip select
- rd out 1: read strobe
- wr out 1: write strobe
- addr out 5: peripheral address
- d_out out 16: write data to peripheral
- d_in in 32: read data from peripheral

Behaviour:
- Reset values:
  - cs, rd, wr, rsp_valid, rsp_err, busy = 0
  - req_ready = 1
  - addr = 0, d_out = 0, rsp_data = 0
  - state = IDLE
  - operand register and counters = 0
- Reset mid-operation aborts immediately. The bus returns to idle asynchronously, and no further strobes are issued.
- Bus cycle rules:
  - Every access is exactly one clk with cs=1 and exactly one of rd/wr =1.
  - Outside an access, cs=rd=wr=0. addr and d_out are don't-care but hold their last value.
  - Read data is sampled from d_in at the end of the cycle after the rd strobe (one-cycle read latency).
- FSM (one state per cycle unless noted):
  - IDLE: on req_valid&&req_ready, latch req_operand and go to WR_A.
  - WR_A: write, addr=ADDR_A, d_out=operand.
  - WR_INIT: write, addr=ADDR_INIT, d_out=16'h0001.
  - GAP: POLL_GAP idle cycles, counted with a 4-bit down-counter.
  - RD_DONE: read, addr=ADDR_DONE.
  - WAIT_D: sample d_in[0]. If 1, go to RD_RES. If 0, increment the poll counter and go to GAP.
  - RD_RES: read, addr=ADDR_RES.
  - WAIT_R: rsp_data <= d_in (full 32 bits).
  - RESP: rsp_valid=1 and rsp_data held stable until rsp_ready. Return to IDLE on the cycle rsp_valid&&rsp_ready.
- Latency: if done=1 at the first poll, rsp_valid rises 7+POLL_GAP cycles after the accept edge (11 with defaults).
- Each further unsuccessful poll adds POLL_GAP+2 cycles.
- rsp_ready high while not in RESP is ignored.
- A req_valid held high while busy is not accepted. It is taken in the first IDLE cycle, which is the cycle after the RESP handshake, so back-to-back requests are possible.
- rsp_err=0 for every normal completion.
- Poll counter is 8 bits and saturates at 255. It is cleared on request accept.

Optional Feature:
- Macro: SQRT_MASTER_TIMEOUT_EN
- Defined:
  - If WAIT_D sees done=0 and the poll counter has reached TIMEOUT, skip RD_RES and go straight to RESP.
  - In that case rsp_err=1 and rsp_data=32'hFFFF_FFFF.
  - rsp_err clears on the RESP handshake.
- Undefined:
  - Polling continues indefinitely.
  - rsp_err is tied to 0.
  - No timeout logic is synthesized.

Test Plan:
- Reset held low mid-poll (state GAP), then released -> cs/rd/wr=0 immediately while low, req_ready=1 and busy=0 after release, no strobe until a new request.
- Request operand 16'h0441, responder model raising done 17 cycles after init -> wr@04 data 0441, then wr@0C data 0001, periodic rd@10, one rd@14; rsp_valid with rsp_data=32'h21, rsp_err=0.
- Responder with done=1 already at the first poll -> exactly one rd@10, rsp_valid exactly 11 cycles after the accept edge.
- rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable for the whole wait; a second req_valid held high during this is accepted only in the first IDLE cycle after the handshake.
- Two back-to-back requests, operands 16'h0010 then 16'h0051 -> responses 32'h4 then 32'h9 in order, no overlapping strobes on the bus.
- With SQRT_MASTER_TIMEOUT_EN, TIMEOUT=3, done never set -> exactly 4 rd@10, no rd@14, rsp_err=1, rsp_data=FFFF_FFFF.

Source files
------------

// File: rtl/sqrt_bus_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sqrt_bus_master                                            |
// | Description : Bus initiator for the sqrt peripheral slave port. On a     |
// |               host request it writes the operand, writes the init        |
// |               command, polls the done register, reads the result and     |
// |               returns it on a valid/ready response port.                 |
// | Option      : define SQRT_MASTER_TIMEOUT_EN to abort after TIMEOUT       |
// |               unsuccessful done polls (rsp_err=1, rsp_data=all ones).    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sqrt_bus_master #(
  parameter logic [4:0]  ADDR_A    = 5'h04,
  parameter logic [4:0]  ADDR_INIT = 5'h0C,
  parameter logic [4:0]  ADDR_DONE = 5'h10,
  parameter logic [4:0]  ADDR_RES  = 5'h14,
  parameter int unsigned POLL_GAP  = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_operand,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        cs,
  output logic        rd,
  output logic        wr,
  output logic [4:0]  addr,
  output logic [15:0] d_out,
  input  logic [31:0] d_in
);

  // Gap counter is loaded with POLL_GAP-1 and exits on zero, giving POLL_GAP idle cycles
  localparam logic [3:0] C_GAP_LOAD = 4'(POLL_GAP - 1);
  localparam logic [7:0] C_TIMEOUT  = 8'(TIMEOUT);
  localparam logic [15:0] C_INIT_CMD = 16'h0001;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WR_A    = 4'd1,
    S_WR_INIT = 4'd2,
    S_GAP     = 4'd3,
    S_RD_DONE = 4'd4,
    S_WAIT_D  = 4'd5,
    S_RD_RES  = 4'd6,
    S_WAIT_R  = 4'd7,
    S_RESP    = 4'd8
  } state_t;

  state_t      r_state;
  state_t      w_state_n;
  logic [3:0]  r_gap_cnt;
  logic [3:0]  w_gap_cnt_n;
  logic        r_cs;
  logic        r_rd;
  logic        r_wr;
  logic [4:0]  r_addr;
  logic [15:0] r_dout;
  logic        w_cs_n;
  logic        w_rd_n;
  logic        w_wr_n;
  logic [4:0]  w_addr_n;
  logic [15:0] w_dout_n;
  logic [31:0] r_rsp_data;
  logic        w_accept;
  logic        w_done;
  logic        w_timeout;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_done    = d_in[0];

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_data  = r_rsp_data;
  assign cs        = r_cs;
  assign rd        = r_rd;
  assign wr        = r_wr;
  assign addr      = r_addr;
  assign d_out     = r_dout;

`ifdef SQRT_MASTER_TIMEOUT_EN
  logic [7:0] r_poll_cnt;
  logic       r_rsp_err;

  assign w_timeout = (r_state == S_WAIT_D) && !w_done && (r_poll_cnt == C_TIMEOUT);
  assign rsp_err   = r_rsp_err;

  // Count unsuccessful done polls, saturating; restart on every accepted request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_poll_cnt <= 8'd0;
    end else if (w_accept) begin
      r_poll_cnt <= 8'd0;
    end else if ((r_state == S_WAIT_D) && !w_done && (r_poll_cnt != 8'hFF)) begin
      r_poll_cnt <= r_poll_cnt + 8'd1;
    end
  end

  // Abort flag raised on timeout, dropped when the host takes the response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_err <= 1'b0;
    end else if (w_timeout) begin
      r_rsp_err <= 1'b1;
    end else if ((r_state == S_RESP) && rsp_ready) begin
      r_rsp_err <= 1'b0;
    end
  end
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign rsp_err          = 1'b0;
  assign w_unused_timeout = ^C_TIMEOUT;
`endif

  // Next-state and gap-counter logic of the transaction sequencer
  always_comb begin
    w_state_n   = r_state;
    w_gap_cnt_n = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        if (req_valid) w_state_n = S_WR_A;
      end
      S_WR_A: begin
        w_state_n = S_WR_INIT;
      end
      S_WR_INIT: begin
        w_state_n   = S_GAP;
        w_gap_cnt_n = C_GAP_LOAD;
      end
      S_GAP: begin
        if (r_gap_cnt == 4'd0) w_state_n = S_RD_DONE;
        else                   w_gap_cnt_n = r_gap_cnt - 4'd1;
      end
      S_RD_DONE: begin
        w_state_n = S_WAIT_D;
      end
      S_WAIT_D: begin
        if (w_done) begin
          w_state_n = S_RD_RES;
        end else if (w_timeout) begin
          w_state_n = S_RESP;
        end else begin
          w_state_n   = S_GAP;
          w_gap_cnt_n = C_GAP_LOAD;
        end
      end
      S_RD_RES: begin
        w_state_n = S_WAIT_R;
      end
      S_WAIT_R: begin
        w_state_n = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  // Bus drive for the upcoming state; addr/d_out keep their last value between accesses.
  // The operand goes straight from req_operand into the d_out register on accept.
  always_comb begin
    w_cs_n   = 1'b0;
    w_rd_n   = 1'b0;
    w_wr_n   = 1'b0;
    w_addr_n = r_addr;
    w_dout_n = r_dout;
    case (w_state_n)
      S_WR_A: begin
        w_cs_n   = 1'b1;
        w_wr_n   = 1'b1;
        w_addr_n = ADDR_A;
        w_dout_n = req_operand;
      end
      S_WR_INIT: begin
        w_cs_n   = 1'b1;
        w_wr_n   = 1'b1;
        w_addr_n = ADDR_INIT;
        w_dout_n = C_INIT_CMD;
      end
      S_RD_DONE: begin
        w_cs_n   = 1'b1;
        w_rd_n   = 1'b1;
        w_addr_n = ADDR_DONE;
      end
      S_RD_RES: begin
        w_cs_n   = 1'b1;
        w_rd_n   = 1'b1;
        w_addr_n = ADDR_RES;
      end
      default: ;
    endcase
  end

  // State, gap counter and registered bus pins; reset drops the bus to idle at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_gap_cnt <= 4'd0;
      r_cs      <= 1'b0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_addr    <= 5'd0;
      r_dout    <= 16'd0;
    end else begin
      r_state   <= w_state_n;
      r_gap_cnt <= w_gap_cnt_n;
      r_cs      <= w_cs_n;
      r_rd      <= w_rd_n;
      r_wr      <= w_wr_n;
      r_addr    <= w_addr_n;
      r_dout    <= w_dout_n;
    end
  end

  // Result capture: full read word in WAIT_R, all ones on a timeout abort
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_data <= 32'd0;
    end else if (r_state == S_WAIT_R) begin
      r_rsp_data <= d_in;
    end else if (w_timeout) begin
      r_rsp_data <= 32'hFFFF_FFFF;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sqrt_bus_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sqrt_bus_master                                         |
// | Description : Directed bench for sqrt_bus_master with a sqrt responder   |
// |               model on the slave side and a bus-access log.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sqrt_bus_master;

  localparam int C_TIMEOUT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_operand = 16'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [4:0]  addr;
  logic [15:0] d_out;
  logic [31:0] d_in = 32'd0;

  int vectors = 0;
  int miscompares = 0;
  int prot_viol = 0;

  // responder state: done_mode 0 = never, 1 = always, 2 = after done_delay cycles from init
  int          done_mode = 1;
  int          done_delay = 0;
  int          cyc = 0;
  int          init_cyc = 0;
  logic [31:0] result_val = 32'd0;

  // bus log entry: {wr, rd, addr[4:0], d_out[15:0]}
  logic [22:0] bus_log[$];

  always #5 clk = ~clk;

  sqrt_bus_master #(.TIMEOUT(C_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_operand(req_operand),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .cs(cs), .rd(rd), .wr(wr), .addr(addr), .d_out(d_out), .d_in(d_in)
  );

  function automatic logic [31:0] isqrt(input logic [15:0] x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= int'(x)) r++;
    return 32'(r);
  endfunction

  function automatic int count_rd(input logic [4:0] a);
    int c;
    c = 0;
    foreach (bus_log[i]) if (bus_log[i][21] && bus_log[i][20:16] == a) c++;
    return c;
  endfunction

  // sqrt peripheral model with one-cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cs === 1'b1 && wr === 1'b1 && addr == 5'h04) result_val <= isqrt(d_out);
    if (cs === 1'b1 && wr === 1'b1 && addr == 5'h0C) init_cyc <= cyc;
    if (cs === 1'b1 && rd === 1'b1) begin
      if (addr == 5'h10)
        d_in <= {31'd0, (done_mode == 1) || (done_mode == 2 && (cyc - init_cyc) >= done_delay)};
      else if (addr == 5'h14)
        d_in <= result_val;
      else
        d_in <= 32'hDEAD_BEEF;
    end
  end

  // bus access logger and strobe-rule watcher
  always @(negedge clk) begin
    if (cs === 1'b1) bus_log.push_back({wr, rd, addr, d_out});
    if ((cs === 1'b1 && rd === wr) || (cs === 1'b0 && (rd === 1'b1 || wr === 1'b1))) prot_viol++;
  end

  task automatic send_req(input logic [15:0] op);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_operand = op;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // counts negedges from the current point until rsp_valid is seen
  task automatic wait_rsp(output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (!ok && n < 300) begin
      @(negedge clk);
      n++;
      if (rsp_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if ({cs, rd, wr} !== 3'b000) begin miscompares++; $display("FAIL reset_strobes got %b want 000", {cs, rd, wr}); end
    vectors++; if ({rsp_valid, rsp_err, busy} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b want 000", {rsp_valid, rsp_err, busy}); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    vectors++; if ({addr, d_out} !== 21'd0) begin miscompares++; $display("FAIL reset_addr_dout got %h/%h want 0/0", addr, d_out); end
    vectors++; if (rsp_data !== 32'd0) begin miscompares++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
    reset = 1'b1;
    @(negedge clk);
    vectors++; if ({req_ready, busy, cs} !== 3'b100) begin miscompares++; $display("FAIL post_reset_idle got %b want 100", {req_ready, busy, cs}); end
  endtask

  task automatic test_reset_mid_poll();
    done_mode = 0;
    send_req(16'h0441);
    repeat (4) @(negedge clk);
    vectors++; if ({busy, cs} !== 2'b10) begin miscompares++; $display("FAIL midpoll_in_gap got %b want 10", {busy, cs}); end
    reset = 1'b0;
    #1;
    vectors++; if ({cs, rd, wr} !== 3'b000) begin miscompares++; $display("FAIL midpoll_strobes_low got %b want 000", {cs, rd, wr}); end
    repeat (3) @(negedge clk);
    vectors++; if ({cs, rd, wr, busy} !== 4'b0000) begin miscompares++; $display("FAIL midpoll_held got %b want 0000", {cs, rd, wr, busy}); end
    reset = 1'b1;
    bus_log.delete();
    repeat (12) @(negedge clk);
    vectors++; if ({req_ready, busy} !== 2'b10) begin miscompares++; $display("FAIL midpoll_after_release got %b want 10", {req_ready, busy}); end
    #1;
    vectors++; if (bus_log.size() !== 0) begin miscompares++; $display("FAIL midpoll_no_strobes got %0d accesses want 0", bus_log.size()); end
  endtask

  task automatic test_poll_forever();
    bit seen;
    done_mode = 0;
    bus_log.delete();
    seen = 1'b0;
    send_req(16'h0441);
    for (int i = 1; i <= 37; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    #1;
    vectors++; if ({cs, rd, addr} !== {2'b11, 5'h10}) begin miscompares++; $display("FAIL forever_sixth_poll got %b/%h want 11/10", {cs, rd}, addr); end
    vectors++; if (count_rd(5'h10) !== 6) begin miscompares++; $display("FAIL forever_poll_count got %0d want 6", count_rd(5'h10)); end
    vectors++; if ({seen, rsp_err} !== 2'b00) begin miscompares++; $display("FAIL forever_no_rsp got %b want 00", {seen, rsp_err}); end
    reset = 1'b0;
    #1;
    vectors++; if ({cs, rd} !== 2'b00) begin miscompares++; $display("FAIL forever_async_reset got %b want 00", {cs, rd}); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int n;
    bit ok;
    done_mode = 2;
    done_delay = 17;
    bus_log.delete();
    send_req(16'h0441);
    wait_rsp(n, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL basic_rsp_timeout got none want rsp_valid"); end
    vectors++; if (rsp_data !== 32'h21) begin miscompares++; $display("FAIL basic_data got %h want 00000021", rsp_data); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL basic_err got %b want 0", rsp_err); end
    finish_rsp();
    vectors++; if (bus_log.size() !== 6) begin miscompares++; $display("FAIL basic_access_count got %0d want 6", bus_log.size()); end
    vectors++; if (bus_log[0] !== {2'b10, 5'h04, 16'h0441}) begin miscompares++; $display("FAIL basic_wr_a got %h want %h", bus_log[0], {2'b10, 5'h04, 16'h0441}); end
    vectors++; if (bus_log[1] !== {2'b10, 5'h0C, 16'h0001}) begin miscompares++; $display("FAIL basic_wr_init got %h want %h", bus_log[1], {2'b10, 5'h0C, 16'h0001}); end
    vectors++; if (count_rd(5'h10) !== 3) begin miscompares++; $display("FAIL basic_polls got %0d want 3", count_rd(5'h10)); end
    vectors++; if (bus_log[5][22:16] !== {2'b01, 5'h14}) begin miscompares++; $display("FAIL basic_rd_res got %h want %h", bus_log[5][22:16], {2'b01, 5'h14}); end
  endtask

  task automatic test_first_poll();
    int n;
    bit ok;
    done_mode = 1;
    bus_log.delete();
    send_req(16'h0051);
    wait_rsp(n, ok);
    vectors++; if (n !== 11) begin miscompares++; $display("FAIL first_poll_latency got %0d want 11", n); end
    vectors++; if (rsp_data !== 32'h9) begin miscompares++; $display("FAIL first_poll_data got %h want 00000009", rsp_data); end
    finish_rsp();
    vectors++; if (count_rd(5'h10) !== 1) begin miscompares++; $display("FAIL first_poll_count got %0d want 1", count_rd(5'h10)); end
  endtask

  task automatic test_hold_and_second_req();
    int n;
    bit ok;
    done_mode = 1;
    send_req(16'h0051);
    wait_rsp(n, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL hold_rsp_timeout got none want rsp_valid"); end
    req_operand = 16'h0010;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if ({rsp_valid, req_ready, rsp_data} !== {2'b10, 32'h9}) begin miscompares++; $display("FAIL hold_stable cyc %0d got %b/%h want 10/00000009", i, {rsp_valid, req_ready}, rsp_data); end
    end
    finish_rsp();
    @(negedge clk);
    vectors++; if ({req_ready, busy, cs} !== 3'b100) begin miscompares++; $display("FAIL hold_first_idle got %b want 100", {req_ready, busy, cs}); end
    @(negedge clk);
    vectors++; if ({busy, cs, wr, addr, d_out} !== {3'b111, 5'h04, 16'h0010}) begin miscompares++; $display("FAIL hold_accept got %b/%h/%h want 111/04/0010", {busy, cs, wr}, addr, d_out); end
    req_valid = 1'b0;
    wait_rsp(n, ok);
    vectors++; if (rsp_data !== 32'h4) begin miscompares++; $display("FAIL hold_second_data got %h want 00000004", rsp_data); end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    logic [31:0] resp[2];
    int got;
    int n;
    done_mode = 1;
    bus_log.delete();
    prot_viol = 0;
    @(negedge clk);
    req_operand = 16'h0010;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_operand = 16'h0051;
    got = 0;
    n = 0;
    while (got < 2 && n < 200) begin
      @(negedge clk);
      n++;
      if (rsp_valid === 1'b1) begin
        resp[got] = rsp_data;
        got++;
      end else if (got == 1 && busy === 1'b1) begin
        req_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    req_valid = 1'b0;
    vectors++; if (got !== 2) begin miscompares++; $display("FAIL b2b_count got %0d want 2", got); end
    vectors++; if (resp[0] !== 32'h4) begin miscompares++; $display("FAIL b2b_first got %h want 00000004", resp[0]); end
    vectors++; if (resp[1] !== 32'h9) begin miscompares++; $display("FAIL b2b_second got %h want 00000009", resp[1]); end
    vectors++; if (bus_log.size() !== 8) begin miscompares++; $display("FAIL b2b_accesses got %0d want 8", bus_log.size()); end
    vectors++; if (bus_log[4] !== {2'b10, 5'h04, 16'h0051}) begin miscompares++; $display("FAIL b2b_second_wr_a got %h want %h", bus_log[4], {2'b10, 5'h04, 16'h0051}); end
    vectors++; if (prot_viol !== 0) begin miscompares++; $display("FAIL b2b_strobe_rules got %0d violations want 0", prot_viol); end
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    done_mode = 0;
    bus_log.delete();
    send_req(16'h0441);
    wait_rsp(n, ok);
    vectors++; if (n !== 27) begin miscompares++; $display("FAIL timeout_latency got %0d want 27", n); end
    vectors++; if ({rsp_err, rsp_data} !== {1'b1, 32'hFFFF_FFFF}) begin miscompares++; $display("FAIL timeout_rsp got %b/%h want 1/ffffffff", rsp_err, rsp_data); end
    vectors++; if (count_rd(5'h10) !== 4) begin miscompares++; $display("FAIL timeout_polls got %0d want 4", count_rd(5'h10)); end
    vectors++; if (count_rd(5'h14) !== 0) begin miscompares++; $display("FAIL timeout_no_rd_res got %0d want 0", count_rd(5'h14)); end
    finish_rsp();
    @(negedge clk);
    vectors++; if ({rsp_err, rsp_valid} !== 2'b00) begin miscompares++; $display("FAIL timeout_err_clear got %b want 00", {rsp_err, rsp_valid}); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_poll();
`ifndef SQRT_MASTER_TIMEOUT_EN
    test_poll_forever();
`endif
    test_basic();
    test_first_poll();
    test_hold_and_second_req();
    test_back_to_back();
`ifdef SQRT_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
